// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions for the instruction loader: loader FSM
// state encoding, instruction width and the default instruction-memory depth.
package cpu_pkg;

    localparam int INST_W            = 32;
    localparam int MEM_DEPTH_DEFAULT = 256;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } loader_state_t;

    // Two's-complement negation of a word; the trailing checksum word of an
    // image must equal this applied to the wrap-around sum of the program.
    function automatic logic [INST_W-1:0] neg_word(input logic [INST_W-1:0] w);
        return ~w + 32'd1;
    endfunction

endpackage

// File: rtl/inst_loader_if.sv
// Program-image bus of the instruction loader: the valid/ready word source
// (inst_Din) and the word-addressed write port into instruction memory.
// slave  = the loader; master = whatever sources words and owns the memory.
interface inst_loader_if #(
    parameter int ADDR_W = 32
) ();

    logic [cpu_pkg::INST_W-1:0] din;
    logic                       din_valid;
    logic                       din_ready;
    logic                       mem_we;
    logic [ADDR_W-1:0]          mem_addr;
    logic [cpu_pkg::INST_W-1:0] mem_wdata;

    modport master (
        output din, din_valid,
        input  din_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  din, din_valid,
        output din_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/loader_addr_gen.sv
// Address side of the instruction loader: latches base and length when a
// load starts, counts written words, forms the next write address and
// checks that the requested image fits in instruction memory.
module loader_addr_gen #(
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 16,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] base_in,
    input  logic [LEN_W-1:0]  len_in,
    output logic [ADDR_W-1:0] addr,
    output logic [LEN_W-1:0]  count,
    output logic              last,
    output logic              oob,
    output logic              zero_len
);

    logic [ADDR_W-1:0] base_r;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  count_r;
    logic [ADDR_W:0]   end_s;

    // One extra bit so a base near the top of the address space cannot wrap
    // and slip past the bounds comparison.
    assign end_s    = {1'b0, base_in} + (ADDR_W+1)'(len_in);
    assign oob      = end_s > (ADDR_W+1)'(MEM_DEPTH);
    assign zero_len = (len_in == {LEN_W{1'b0}});
    assign addr     = base_r + ADDR_W'(count_r);
    assign last     = (count_r == (len_r - {{(LEN_W-1){1'b0}}, 1'b1}));
    assign count    = count_r;

    // Base/length capture on start and per-word counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_r  <= {ADDR_W{1'b0}};
            len_r   <= {LEN_W{1'b0}};
            count_r <= {LEN_W{1'b0}};
        end else if (load) begin
            base_r  <= base_in;
            len_r   <= len_in;
            count_r <= {LEN_W{1'b0}};
        end else if (step) begin
            count_r <= count_r + {{(LEN_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/inst_loader.sv
// Instruction-memory loader: streams a program image from inst_Din into
// instruction memory and holds the CPU until the whole image is written.
// Optional build macro LOADER_CHECKSUM_EN adds a trailing checksum word
// (CHECK state) and the sum_out port.
module inst_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT,
    parameter int LEN_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [LEN_W-1:0]  load_len,
    inst_loader_if.slave      bus,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [LEN_W-1:0]  word_count
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [INST_W-1:0] sum_out
`endif
);

    loader_state_t     state_r, next_state_s;
    logic              start_ok_s, xfer_s, load_xfer_s;
    logic              last_s, oob_s, zero_len_s;
    logic [ADDR_W-1:0] addr_s;
    logic              din_ready_r, busy_r, done_r, error_r, hold_r, mem_we_r;
    logic              din_ready_n_s, busy_n_s, done_n_s, error_n_s, hold_n_s, mem_we_n_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_n_s;
    logic [INST_W-1:0] mem_wdata_r, mem_wdata_n_s;

    assign start_ok_s  = start && ((state_r == IDLE) || (state_r == DONE) || (state_r == ERR));
    assign xfer_s      = bus.din_valid && din_ready_r;
    assign load_xfer_s = xfer_s && (state_r == LOAD);

`ifdef LOADER_CHECKSUM_EN
    logic [INST_W-1:0] sum_r;
    logic              check_xfer_s, sum_ok_s;

    assign check_xfer_s = xfer_s && (state_r == CHECK);
    assign sum_ok_s     = (bus.din == neg_word(sum_r));
    assign sum_out      = sum_r;

    // Wrap-around sum of the program words written in this load.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r <= 32'd0;
        end else if (start_ok_s) begin
            sum_r <= 32'd0;
        end else if (load_xfer_s) begin
            sum_r <= sum_r + bus.din;
        end else begin
            sum_r <= sum_r;
        end
    end
`endif

    loader_addr_gen #(
        .ADDR_W    (ADDR_W),
        .LEN_W     (LEN_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (start_ok_s),
        .step     (load_xfer_s),
        .base_in  (load_base),
        .len_in   (load_len),
        .addr     (addr_s),
        .count    (word_count),
        .last     (last_s),
        .oob      (oob_s),
        .zero_len (zero_len_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE, DONE, ERR: begin
                if (start_ok_s) begin
                    if (oob_s) begin
                        next_state_s = ERR;
                    end else if (zero_len_s) begin
                        next_state_s = DONE;
                    end else begin
                        next_state_s = LOAD;
                    end
                end else begin
                    next_state_s = state_r;
                end
            end
            LOAD: begin
                if (load_xfer_s && last_s) begin
`ifdef LOADER_CHECKSUM_EN
                    next_state_s = CHECK;
`else
                    next_state_s = DONE;
`endif
                end else begin
                    next_state_s = LOAD;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (check_xfer_s) begin
                    next_state_s = sum_ok_s ? DONE : ERR;
                end else begin
                    next_state_s = CHECK;
                end
            end
`endif
            default: next_state_s = IDLE;
        endcase
    end

    // Next values of the registered outputs. Status flags follow the
    // upcoming state; cpu_hold only drops after a full cycle in DONE so the
    // final write lands before the first fetch.
    always_comb begin
        busy_n_s      = (next_state_s == LOAD) || (next_state_s == CHECK);
        din_ready_n_s = (next_state_s == LOAD) || (next_state_s == CHECK);
        done_n_s      = (next_state_s == DONE);
        error_n_s     = (next_state_s == ERR);
        mem_we_n_s    = load_xfer_s;
        if ((state_r == DONE) && !start_ok_s) begin
            hold_n_s = 1'b0;
        end else begin
            hold_n_s = 1'b1;
        end
        if (load_xfer_s) begin
            mem_addr_n_s  = addr_s;
            mem_wdata_n_s = bus.din;
        end else begin
            mem_addr_n_s  = mem_addr_r;
            mem_wdata_n_s = mem_wdata_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            din_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
            hold_r      <= 1'b1;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= 32'd0;
        end else begin
            din_ready_r <= din_ready_n_s;
            busy_r      <= busy_n_s;
            done_r      <= done_n_s;
            error_r     <= error_n_s;
            hold_r      <= hold_n_s;
            mem_we_r    <= mem_we_n_s;
            mem_addr_r  <= mem_addr_n_s;
            mem_wdata_r <= mem_wdata_n_s;
        end
    end

    assign bus.din_ready = din_ready_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign error         = error_r;
    assign cpu_hold      = hold_r;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: normal, throttled, out-of-bounds, exact
// fit, zero-length and reset-during-load images, plus the checksum trailer
// when LOADER_CHECKSUM_EN is defined.
module tb_inst_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] load_base;
    logic [15:0] load_len;
    logic        cpu_hold, busy, done, error;
    logic [15:0] word_count;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] sum_out;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic [31:0] feed_words [0:7];

    inst_loader_if #(.ADDR_W(32)) bus ();

    inst_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .load_base  (load_base),
        .load_len   (load_len),
        .bus        (bus),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count)
`ifdef LOADER_CHECKSUM_EN
        ,
        .sum_out    (sum_out)
`endif
    );

    always #5 clk = ~clk;

    // Log every memory write pulse seen by instruction memory.
    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wa.push_back(bus.mem_addr);
            wd.push_back(bus.mem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] base, input logic [15:0] len);
        wa.delete();
        wd.delete();
        start     = 1'b1;
        load_base = base;
        load_len  = len;
        tick();
        start     = 1'b0;
    endtask

    // Present n words from feed_words; a word advances only on an edge
    // where valid and ready were both high.
    task automatic feed(input int n, input bit throttle);
        int  idx = 0;
        int  cyc = 0;
        bit  ok;
        while (idx < n && cyc < 200) begin
            bus.din_valid = throttle ? (cyc % 2 == 1) : 1'b1;
            bus.din       = feed_words[idx];
            ok            = bus.din_valid && (bus.din_ready === 1'b1);
            tick();
            if (ok) idx++;
            cyc++;
        end
        bus.din_valid = 1'b0;
        chk("feed_accepted", idx, n);
    endtask

    // Program words plus, in checksum builds, the matching trailer word.
    task automatic load_prog(input int n, input bit throttle);
`ifdef LOADER_CHECKSUM_EN
        logic [31:0] s = 32'd0;
        for (int i = 0; i < n; i++) s += feed_words[i];
        feed_words[n] = -s;
        feed(n + 1, throttle);
`else
        feed(n, throttle);
`endif
    endtask

    task automatic verify_writes(input logic [31:0] base, input int n);
        chk("write_count", wa.size(), n);
        for (int i = 0; i < n; i++) begin
            chk("write_addr", (i < wa.size()) ? wa[i] : 32'hxxxxxxxx, base + i);
            chk("write_data", (i < wd.size()) ? wd[i] : 32'hxxxxxxxx, feed_words[i]);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_mem_we"},     bus.mem_we,    1'b0);
        chk({tag, "_mem_addr"},   bus.mem_addr,  32'd0);
        chk({tag, "_mem_wdata"},  bus.mem_wdata, 32'd0);
        chk({tag, "_din_ready"},  bus.din_ready, 1'b0);
        chk({tag, "_busy"},       busy,          1'b0);
        chk({tag, "_done"},       done,          1'b0);
        chk({tag, "_error"},      error,         1'b0);
        chk({tag, "_word_count"}, word_count,    16'd0);
        chk({tag, "_cpu_hold"},   cpu_hold,      1'b1);
`ifdef LOADER_CHECKSUM_EN
        chk({tag, "_sum_out"},    sum_out,       32'd0);
`endif
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        load_base     = 32'd0;
        load_len      = 16'd0;
        bus.din       = 32'd0;
        bus.din_valid = 1'b0;
        repeat (3) tick();
        chk_reset("reset");
        rst = 1'b0;
        tick();

        // Back-to-back load of three words at 0x10.
        feed_words[0] = 32'hA;
        feed_words[1] = 32'hB;
        feed_words[2] = 32'hC;
        do_start(32'h10, 16'd3);
        chk("t1_busy", busy, 1'b1);
        chk("t1_din_ready", bus.din_ready, 1'b1);
        chk("t1_hold_loading", cpu_hold, 1'b1);
        load_prog(3, 1'b0);
`ifndef LOADER_CHECKSUM_EN
        chk("t1_last_we", bus.mem_we, 1'b1);
        chk("t1_last_addr", bus.mem_addr, 32'h12);
        chk("t1_last_data", bus.mem_wdata, 32'hC);
`endif
        chk("t1_done", done, 1'b1);
        chk("t1_ready_dropped", bus.din_ready, 1'b0);
        chk("t1_word_count", word_count, 16'd3);
        chk("t1_hold_at_last", cpu_hold, 1'b1);
        tick();
        chk("t1_hold_released", cpu_hold, 1'b0);
        chk("t1_we_idle", bus.mem_we, 1'b0);
        verify_writes(32'h10, 3);

        // Same image with valid low on alternate cycles.
        do_start(32'h10, 16'd3);
        chk("t2_done_cleared", done, 1'b0);
        chk("t2_hold_set", cpu_hold, 1'b1);
        load_prog(3, 1'b1);
        chk("t2_done", done, 1'b1);
        chk("t2_word_count", word_count, 16'd3);
        tick();
        chk("t2_hold_released", cpu_hold, 1'b0);
        verify_writes(32'h10, 3);

        // Out of bounds: 254 + 4 > 256.
        do_start(32'd254, 16'd4);
        chk("t3_error", error, 1'b1);
        chk("t3_busy", busy, 1'b0);
        chk("t3_din_ready", bus.din_ready, 1'b0);
        chk("t3_hold", cpu_hold, 1'b1);
        bus.din_valid = 1'b1;
        repeat (3) tick();
        bus.din_valid = 1'b0;
        chk("t3_no_writes", wa.size(), 0);
        chk("t3_error_sticky", error, 1'b1);
        chk("t3_hold_sticky", cpu_hold, 1'b1);

        // Exact fit: 252 + 4 == 256 is allowed.
        feed_words[0] = 32'h1111_0000;
        feed_words[1] = 32'h2222_0001;
        feed_words[2] = 32'h3333_0002;
        feed_words[3] = 32'h4444_0003;
        do_start(32'd252, 16'd4);
        chk("t3b_error_cleared", error, 1'b0);
        chk("t3b_busy", busy, 1'b1);
        load_prog(4, 1'b0);
        tick();
        chk("t3b_done", done, 1'b1);
        verify_writes(32'd252, 4);

        // Zero-length image.
        do_start(32'd5, 16'd0);
        chk("t4_done", done, 1'b1);
        chk("t4_busy", busy, 1'b0);
        tick();
        chk("t4_hold_released", cpu_hold, 1'b0);
        chk("t4_no_writes", wa.size(), 0);
        chk("t4_word_count", word_count, 16'd0);

        // Reset after two of five words, then a full restart.
        feed_words[0] = 32'hDEAD_0000;
        feed_words[1] = 32'hDEAD_0001;
        feed_words[2] = 32'hDEAD_0002;
        feed_words[3] = 32'hDEAD_0003;
        feed_words[4] = 32'hDEAD_0004;
        do_start(32'h20, 16'd5);
        feed(2, 1'b0);
        chk("t5_partial_count", word_count, 16'd2);
        rst = 1'b1;
        tick();
        chk_reset("t5_midreset");
        rst = 1'b0;
        do_start(32'h20, 16'd5);
        load_prog(5, 1'b0);
        tick();
        chk("t5_done", done, 1'b1);
        chk("t5_word_count", word_count, 16'd5);
        verify_writes(32'h20, 5);

`ifdef LOADER_CHECKSUM_EN
        // Good trailer: 1+2+3 = 6, negated = 0xFFFFFFFA.
        feed_words[0] = 32'd1;
        feed_words[1] = 32'd2;
        feed_words[2] = 32'd3;
        feed_words[3] = 32'hFFFF_FFFA;
        do_start(32'h40, 16'd3);
        feed(4, 1'b0);
        chk("c1_done", done, 1'b1);
        chk("c1_error", error, 1'b0);
        chk("c1_sum", sum_out, 32'd6);
        tick();
        chk("c1_writes", wa.size(), 3);
        chk("c1_hold_released", cpu_hold, 1'b0);

        // Bad trailer.
        feed_words[3] = 32'd0;
        do_start(32'h40, 16'd3);
        feed(4, 1'b0);
        chk("c2_error", error, 1'b1);
        chk("c2_done", done, 1'b0);
        tick();
        chk("c2_writes", wa.size(), 3);
        chk("c2_hold", cpu_hold, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
